// File: rtl/sda_gmem_pkg.sv
// sda_gmem_pkg: shared burst/response codes and FSM encodings for the gmem slave RAM.
package sda_gmem_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
endpackage

// File: rtl/sda_gmem_rd_skid.sv
// sda_gmem_rd_skid: 2-entry FIFO between the RAM read port and the R channel.
module sda_gmem_rd_skid #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] e1;
    logic pop;
    assign out_valid = count != 2'd0;
    assign pop = out_valid & out_ready;
    // Upstream only pushes when it has reserved a free slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            out_data <= '0;
            e1 <= '0;
        end else begin
            count <= count + {1'b0, in_valid} - {1'b0, pop};
            if (count == 2'd0 || (pop && count == 2'd1))
                out_data <= in_data;
            else if (pop)
                out_data <= e1;
            if (in_valid && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
                e1 <= in_data;
        end
    end
endmodule

// File: rtl/sda_gmem_axi_slave_ram.sv
// sda_gmem_axi_slave_ram: AXI4 burst slave backed by on-chip RAM.
// SDA_GMEM_RAM_RANGE_CHECK_EN flags out-of-range beats with SLVERR instead of wrapping.
module sda_gmem_axi_slave_ram
    import sda_gmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 1,
    parameter int MEM_AW = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int OFF   = MEM_AW + LB;
    localparam int SKW   = DATA_W + 2 + 1 + ID_W;

    logic [DATA_W-1:0] mem [2**MEM_AW];

    wr_state_t wr_st;
    logic [ADDR_W-1:0] waddr, waddr_nxt;
    logic [7:0] wlen, wcnt;
    logic [2:0] wsize;
    logic [1:0] wburst;
    logic werr, w_hs, w_oor, w_end, w_bad;

    rd_state_t rd_st;
    logic [ADDR_W-1:0] raddr, raddr_nxt;
    logic [7:0] rlen, rcnt;
    logic [2:0] rsize;
    logic [1:0] rburst;
    logic [ID_W-1:0] rid_q;
    logic rd_more, rd_pend, r_oor, issue, pop;
    logic [DATA_W-1:0] rd_q;
    logic rd_err, rd_last;
    logic [1:0] sk_cnt;
    logic [2:0] occ;

`ifdef SDA_GMEM_RAM_RANGE_CHECK_EN
    assign w_oor = |(waddr >> OFF);
    assign r_oor = |(raddr >> OFF);
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign w_hs = s_axi_wready & s_axi_wvalid;
    assign w_end = wcnt == wlen;
    assign w_bad = s_axi_wlast != w_end;
    assign waddr_nxt = (wburst == BURST_FIXED) ? waddr : waddr + (ADDR_W'(1) << wsize);
    assign raddr_nxt = (rburst == BURST_FIXED) ? raddr : raddr + (ADDR_W'(1) << rsize);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_st <= WR_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
            werr <= 1'b0;
        end else begin
            case (wr_st)
                WR_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awready && s_axi_awvalid) begin
                        waddr <= s_axi_awaddr;
                        wlen <= s_axi_awlen;
                        wsize <= s_axi_awsize;
                        wburst <= s_axi_awburst;
                        s_axi_bid <= s_axi_awid;
                        wcnt <= 8'd0;
                        werr <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready <= 1'b1;
                        wr_st <= WR_DATA;
                    end
                end
                WR_DATA: if (w_hs) begin
                    wcnt <= wcnt + 8'd1;
                    waddr <= waddr_nxt;
                    werr <= werr | w_bad | w_oor;
                    if (w_end) begin
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp <= (werr | w_bad | w_oor) ? RESP_SLVERR : RESP_OKAY;
                        wr_st <= WR_RESP;
                    end
                end
                default: if (s_axi_bready) begin
                    s_axi_bvalid <= 1'b0;
                    s_axi_awready <= 1'b1;
                    wr_st <= WR_IDLE;
                end
            endcase
        end
    end

    // Read-first: the read port sees the value before any same-cycle write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++)
            if (w_hs && !w_oor && s_axi_wstrb[b])
                mem[waddr[OFF-1:LB]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        if (issue) begin
            rd_q <= mem[raddr[OFF-1:LB]];
            rd_err <= r_oor;
            rd_last <= rcnt == rlen;
        end
    end

    // Keep at most two beats in flight or buffered so the skid never overflows.
    assign pop = s_axi_rvalid & s_axi_rready;
    assign occ = {1'b0, sk_cnt} + {2'b0, rd_pend} - {2'b0, pop};
    assign issue = (rd_st == RD_BURST) && rd_more && occ < 3'd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_st <= RD_IDLE;
            s_axi_arready <= 1'b0;
            rd_more <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= issue;
            case (rd_st)
                RD_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arready && s_axi_arvalid) begin
                        raddr <= s_axi_araddr;
                        rlen <= s_axi_arlen;
                        rsize <= s_axi_arsize;
                        rburst <= s_axi_arburst;
                        rid_q <= s_axi_arid;
                        rcnt <= 8'd0;
                        rd_more <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rd_st <= RD_BURST;
                    end
                end
                default: begin
                    if (issue) begin
                        rcnt <= rcnt + 8'd1;
                        raddr <= raddr_nxt;
                        if (rcnt == rlen) rd_more <= 1'b0;
                    end
                    if (pop && s_axi_rlast) begin
                        s_axi_arready <= 1'b1;
                        rd_st <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    sda_gmem_rd_skid #(.W(SKW)) u_skid (
        .clk(clk),
        .reset(reset),
        .in_valid(rd_pend),
        .in_data({rd_err ? {DATA_W{1'b0}} : rd_q, rd_err ? RESP_SLVERR : RESP_OKAY, rd_last, rid_q}),
        .out_valid(s_axi_rvalid),
        .out_ready(s_axi_rready),
        .out_data({s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}),
        .count(sk_cnt)
    );
endmodule
